// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32I hazard/redirect controller.
package hazard_pkg;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FWD_REG = 2'd0, FWD_ALU_E = 2'd1, FWD_WB = 2'd2} fwd_sel_t;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, REDIR = 2'd2} hz_state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       wr_rd;
    logic       rd_rs1;
    logic       rd_rs2;
    logic       is_load;
  } reg_use_t;

  // True when a used source register is produced by instruction p.
  function automatic logic src_match(logic used, logic [4:0] rs, reg_use_t p);
    return used && p.wr_rd && (rs == p.rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle: instructions in each stage in, hazard controls out.
interface pipe_hazard_ctrl_if #(parameter int XLEN = 32);
  logic [31:0]     instr_F, instr_D, instr_E, instr_M;
  logic            pc_sel, hold;
  logic            stall_F, bubble_D, flush_F, flush_D, freeze;
  logic            dec_byp_a, dec_byp_b;
  logic [1:0]      fwd_a_sel, fwd_b_sel, state;
  logic [XLEN-1:0] stall_cnt, flush_cnt;

  modport master (
    output instr_F, instr_D, instr_E, instr_M, pc_sel, hold,
    input  stall_F, bubble_D, flush_F, flush_D, freeze, dec_byp_a, dec_byp_b,
    input  fwd_a_sel, fwd_b_sel, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  instr_F, instr_D, instr_E, instr_M, pc_sel, hold,
    output stall_F, bubble_D, flush_F, flush_D, freeze, dec_byp_a, dec_byp_b,
    output fwd_a_sel, fwd_b_sel, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_reg_use_decode.sv
// Per-stage decode of which architectural registers an instruction reads/writes.
module reg_use_decode
  import hazard_pkg::*;
#(
  parameter logic [31:0] NOP = hazard_pkg::NOP
) (
  input  logic [31:0] instr_i,
  output reg_use_t    ru_o
);

  logic [6:0] opc;
  logic       empty;

  assign opc   = instr_i[6:0];
  assign empty = (instr_i == NOP) || (instr_i == '0);

  always_comb begin
    ru_o     = '0;
    ru_o.rd  = instr_i[11:7];
    ru_o.rs1 = instr_i[19:15];
    ru_o.rs2 = instr_i[24:20];
    case (opc)
      LUI, AUIPC, JAL: ru_o.wr_rd = 1'b1;
      JALR:   begin ru_o.wr_rd = 1'b1; ru_o.rd_rs1 = 1'b1; end
      BRANCH: begin ru_o.rd_rs1 = 1'b1; ru_o.rd_rs2 = 1'b1; end
      LOAD:   begin ru_o.wr_rd = 1'b1; ru_o.rd_rs1 = 1'b1; ru_o.is_load = 1'b1; end
      STORE:  begin ru_o.rd_rs1 = 1'b1; ru_o.rd_rs2 = 1'b1; end
      OP_IMM: begin ru_o.wr_rd = 1'b1; ru_o.rd_rs1 = 1'b1; end
      OP:     begin ru_o.wr_rd = 1'b1; ru_o.rd_rs1 = 1'b1; ru_o.rd_rs2 = 1'b1; end
      default: ;
    endcase
    // x0 is hardwired, so a write to it produces nothing to forward.
    if (ru_o.rd == 5'd0) ru_o.wr_rd = 1'b0;
    if (empty) ru_o = '0;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush/bypass generation for the F->D->E->M register pipeline,
// with a small sequencing FSM and stall/flush event counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int          XLEN = 32,
  parameter logic [31:0] NOP  = hazard_pkg::NOP
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int NSTG = 4;

  logic [NSTG-1:0][31:0] instr;
  reg_use_t              ru [NSTG];

  assign instr = {hz.instr_M, hz.instr_E, hz.instr_D, hz.instr_F};

  for (genvar g = 0; g < NSTG; g++) begin : g_dec
    reg_use_decode #(.NOP(NOP)) u_dec (.instr_i(instr[g]), .ru_o(ru[g]));
  end

  reg_use_t ru_f, ru_d, ru_e, ru_m;
  assign ru_f = ru[0];
  assign ru_d = ru[1];
  assign ru_e = ru[2];
  assign ru_m = ru[3];

  logic unused_ru;
  assign unused_ru = ^{ru_f, ru_d, ru_e, ru_m};

  logic ld_use, redirect, lu_stall;

  assign ld_use   = ru_d.is_load &&
                    (src_match(ru_f.rd_rs1, ru_f.rs1, ru_d) ||
                     src_match(ru_f.rd_rs2, ru_f.rs2, ru_d));
  assign redirect = !hz.hold && hz.pc_sel;
  assign lu_stall = !hz.hold && !hz.pc_sel && ld_use;

  assign hz.freeze    = hz.hold;
  assign hz.stall_F   = lu_stall;
  assign hz.bubble_D  = lu_stall;
  assign hz.flush_F   = redirect;
  assign hz.flush_D   = redirect;
  assign hz.dec_byp_a = !hz.hold && src_match(ru_f.rd_rs1, ru_f.rs1, ru_m);
  assign hz.dec_byp_b = !hz.hold && src_match(ru_f.rd_rs2, ru_f.rs2, ru_m);

  // A load in D has no ALU result yet; its consumer is stalled until it reaches E.
  function automatic fwd_sel_t fwd_pick(logic used, logic [4:0] rs, reg_use_t d, reg_use_t e);
    if (src_match(used, rs, d) && !d.is_load) return FWD_ALU_E;
    if (src_match(used, rs, e))               return FWD_WB;
    return FWD_REG;
  endfunction

  fwd_sel_t        fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
  hz_state_t       state_d, state_q;
  logic [XLEN-1:0] stall_cnt_q, flush_cnt_q;

  assign fwd_a_d = fwd_pick(ru_f.rd_rs1, ru_f.rs1, ru_d, ru_e);
  assign fwd_b_d = fwd_pick(ru_f.rd_rs2, ru_f.rs2, ru_d, ru_e);

  always_comb begin
    state_d = state_q;
    if (!hz.hold) begin
      if (redirect)      state_d = REDIR;
      else if (lu_stall) state_d = STALL;
      else               state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Bubble/flush zero the selects along with the D-reg; stall always pairs with bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!hz.hold) begin
      if (lu_stall || redirect) begin
        fwd_a_q <= FWD_REG;
        fwd_b_q <= FWD_REG;
      end else begin
        fwd_a_q <= fwd_a_d;
        fwd_b_q <= fwd_b_d;
      end
      if (lu_stall) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.fwd_a_sel = fwd_a_q;
  assign hz.fwd_b_sel = fwd_b_q;
  assign hz.state     = state_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl_if #(.XLEN(32)) hz();

  pipe_hazard_ctrl #(.XLEN(32), .NOP(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_STF = 0, S_BUB = 1, S_FLF = 2, S_FLD = 3, S_FRZ = 4, S_BPA = 5, S_BPB = 6;
  localparam int S_FWA = 7, S_FWB = 8, S_ST = 9, S_SC = 10, S_FC = 11;

  localparam logic [31:0] I_NOP = 32'h0000_0013;
  localparam logic [31:0] ADDI1 = {12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011};
  localparam logic [31:0] ADDI7 = {12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011};
  localparam logic [31:0] BEQ   = {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011};

  function automatic logic [31:0] add_r(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw(logic [4:0] rd, logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];

  task automatic push(string tag, int sig, logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = v;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] obs(int sig);
    case (sig)
      S_STF:   return {31'd0, hz.stall_F};
      S_BUB:   return {31'd0, hz.bubble_D};
      S_FLF:   return {31'd0, hz.flush_F};
      S_FLD:   return {31'd0, hz.flush_D};
      S_FRZ:   return {31'd0, hz.freeze};
      S_BPA:   return {31'd0, hz.dec_byp_a};
      S_BPB:   return {31'd0, hz.dec_byp_b};
      S_FWA:   return {30'd0, hz.fwd_a_sel};
      S_FWB:   return {30'd0, hz.fwd_b_sel};
      S_ST:    return {30'd0, hz.state};
      S_SC:    return hz.stall_cnt;
      S_FC:    return hz.flush_cnt;
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic check_all();
    exp_t        e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sig);
      checks++;
      assert (o === e.val)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic exp_comb(string p, logic sf, logic bd, logic ff, logic fd, logic fz, logic ba, logic bb);
    push({p, ".stall_F"},  S_STF, {31'd0, sf});
    push({p, ".bubble_D"}, S_BUB, {31'd0, bd});
    push({p, ".flush_F"},  S_FLF, {31'd0, ff});
    push({p, ".flush_D"},  S_FLD, {31'd0, fd});
    push({p, ".freeze"},   S_FRZ, {31'd0, fz});
    push({p, ".byp_a"},    S_BPA, {31'd0, ba});
    push({p, ".byp_b"},    S_BPB, {31'd0, bb});
  endtask

  task automatic exp_reg(string p, int fa, int fb, int st, int sc, int fc);
    push({p, ".fwd_a"},     S_FWA, 32'(fa));
    push({p, ".fwd_b"},     S_FWB, 32'(fb));
    push({p, ".state"},     S_ST,  32'(st));
    push({p, ".stall_cnt"}, S_SC,  32'(sc));
    push({p, ".flush_cnt"}, S_FC,  32'(fc));
  endtask

  task automatic step(logic [31:0] f, logic [31:0] d, logic [31:0] e, logic [31:0] m, logic pc, logic hd);
    @(negedge clk);
    hz.instr_F = f; hz.instr_D = d; hz.instr_E = e; hz.instr_M = m;
    hz.pc_sel = pc; hz.hold = hd;
  endtask

  task automatic settle();
    #1 check_all();
  endtask

  task automatic edge_chk();
    @(posedge clk);
    #1 check_all();
  endtask

  initial begin
    rst = 1'b0;
    hz.instr_F = '0; hz.instr_D = '0; hz.instr_E = '0; hz.instr_M = '0;
    hz.pc_sel = 1'b0; hz.hold = 1'b0;
    #3;
    exp_comb("rst", 0, 0, 0, 0, 0, 0, 0);
    exp_reg("rst", 0, 0, 0, 0, 0);
    check_all();
    @(negedge clk) rst = 1'b1;

    // ALU producer directly ahead of consumer
    step(add_r(2, 1, 1), ADDI1, I_NOP, I_NOP, 0, 0);
    exp_comb("alu", 0, 0, 0, 0, 0, 0, 0); settle();
    exp_reg("alu", 1, 1, 0, 0, 0); edge_chk();
    step(I_NOP, add_r(2, 1, 1), ADDI1, I_NOP, 0, 0);
    exp_comb("alu2", 0, 0, 0, 0, 0, 0, 0); settle();
    exp_reg("alu2", 0, 0, 0, 0, 0); edge_chk();

    // load-use: one stall+bubble, then forward from writeback
    step(add_r(4, 3, 0), lw(3, 0), I_NOP, I_NOP, 0, 0);
    exp_comb("lu", 1, 1, 0, 0, 0, 0, 0); settle();
    exp_reg("lu", 0, 0, 1, 1, 0); edge_chk();
    step(add_r(4, 3, 0), I_NOP, lw(3, 0), I_NOP, 0, 0);
    exp_comb("lu2", 0, 0, 0, 0, 0, 0, 0); settle();
    exp_reg("lu2", 2, 0, 0, 1, 0); edge_chk();

    // x0 producers never create hazards
    step(add_r(6, 0, 0), lw(0, 5), add_r(0, 5, 5), I_NOP, 0, 0);
    exp_comb("x0", 0, 0, 0, 0, 0, 0, 0); settle();
    exp_reg("x0", 0, 0, 0, 1, 0); edge_chk();

    // youngest producer wins; older-only match selects writeback
    step(add_r(2, 1, 1), ADDI1, ADDI1, I_NOP, 0, 0);
    exp_comb("young", 0, 0, 0, 0, 0, 0, 0); settle();
    exp_reg("young", 1, 1, 0, 1, 0); edge_chk();
    step(add_r(2, 1, 0), I_NOP, ADDI1, I_NOP, 0, 0);
    exp_comb("old", 0, 0, 0, 0, 0, 0, 0); settle();
    exp_reg("old", 2, 0, 0, 1, 0); edge_chk();

    // redirect suppresses a coincident load-use
    step(add_r(4, 3, 0), lw(3, 0), BEQ, I_NOP, 1, 0);
    exp_comb("redir", 0, 0, 1, 1, 0, 0, 0); settle();
    exp_reg("redir", 0, 0, 2, 1, 1); edge_chk();
    step(I_NOP, I_NOP, I_NOP, I_NOP, 0, 0);
    exp_comb("idle", 0, 0, 0, 0, 0, 0, 0); settle();
    exp_reg("idle", 0, 0, 0, 1, 1); edge_chk();

    // redirect arriving while in STALL
    step(add_r(4, 3, 0), lw(3, 0), I_NOP, I_NOP, 0, 0);
    exp_comb("lu3", 1, 1, 0, 0, 0, 0, 0); settle();
    exp_reg("lu3", 0, 0, 1, 2, 1); edge_chk();
    step(I_NOP, I_NOP, I_NOP, I_NOP, 1, 0);
    exp_comb("st2rd", 0, 0, 1, 1, 0, 0, 0); settle();
    exp_reg("st2rd", 0, 0, 2, 2, 2); edge_chk();
    step(I_NOP, I_NOP, I_NOP, I_NOP, 0, 0);
    exp_reg("back", 0, 0, 0, 2, 2); edge_chk();

    // decode bypass from M-reg
    step(add_r(8, 7, 9), I_NOP, I_NOP, ADDI7, 0, 0);
    exp_comb("bypa", 0, 0, 0, 0, 0, 1, 0); settle();
    step(add_r(8, 9, 7), I_NOP, I_NOP, ADDI7, 0, 0);
    exp_comb("bypb", 0, 0, 0, 0, 0, 0, 1); settle();
    exp_reg("byp", 0, 0, 0, 2, 2); edge_chk();

    // hold during STALL freezes everything, then async reset
    step(add_r(4, 3, 0), lw(3, 0), I_NOP, I_NOP, 0, 0);
    exp_reg("lu4", 0, 0, 1, 3, 2); edge_chk();
    for (int i = 0; i < 3; i++) begin
      step(add_r(2, 1, 1), ADDI1, I_NOP, ADDI1, (i == 1), 1);
      exp_comb($sformatf("hold%0d", i), 0, 0, 0, 0, 1, 0, 0); settle();
      exp_reg($sformatf("hold%0d", i), 0, 0, 1, 3, 2); edge_chk();
    end
    @(negedge clk) rst = 1'b0;
    #1;
    exp_reg("arst", 0, 0, 0, 0, 0); check_all();
    @(negedge clk) rst = 1'b1;
    step(I_NOP, I_NOP, I_NOP, I_NOP, 0, 0);
    exp_comb("post", 0, 0, 0, 0, 0, 0, 0); settle();
    exp_reg("post", 0, 0, 0, 0, 0); edge_chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
